// File: rtl/jtkcpu_regrd.sv
// jtkcpu_regrd: source-side reader and write sequencer for the KONAMI-1
// TFR (8'h3F) and EXG (8'h3E) instructions. Both operands are sampled from
// the register bank when the request is accepted. After that, one register
// write is presented per step: the destination first, and the source second
// when the instruction is EXG. Every output is registered and holds its level
// while cen is low. The register file qualifies wr with cen.
module jtkcpu_regrd (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [7:0]  opnd0,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [7:0]  cc,
  output logic        busy,
  output logic        done,
  output logic        wr,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_data,
  output logic        illegal
);

  localparam logic [7:0] OP_EXG = 8'h3E;
  localparam logic [7:0] OP_TFR = 8'h3F;

  // Register codes, shared by the postbyte nibbles and wr_sel
  localparam logic [3:0] RC_D  = 4'h0;
  localparam logic [3:0] RC_X  = 4'h1;
  localparam logic [3:0] RC_Y  = 4'h2;
  localparam logic [3:0] RC_U  = 4'h3;
  localparam logic [3:0] RC_S  = 4'h4;
  localparam logic [3:0] RC_PC = 4'h5;
  localparam logic [3:0] RC_DP = 4'h8;
  localparam logic [3:0] RC_CC = 4'h9;
  localparam logic [3:0] RC_A  = 4'hA;
  localparam logic [3:0] RC_B  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the ten register codes the CPU implements
  function automatic logic code_valid(input logic [3:0] code);
    logic ok;
    ok = 1'b0;
    case (code)
      RC_D, RC_X, RC_Y, RC_U, RC_S, RC_PC,
      RC_DP, RC_CC, RC_A, RC_B: ok = 1'b1;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the byte-wide registers
  function automatic logic code_is8(input logic [3:0] code);
    return (code == RC_DP) || (code == RC_CC) || (code == RC_A) || (code == RC_B);
  endfunction

  // Shape a 16-bit operand for the target width: byte targets see FF in the
  // upper half, matching how byte registers read back
  function automatic logic [15:0] write_value(input logic [3:0] code,
                                              input logic [15:0] val);
    return code_is8(code) ? {8'hFF, val[7:0]} : val;
  endfunction

  // Register bank read mux; invalid codes read as all ones
  logic [15:0] rd_src;
  logic [15:0] rd_dst;
  logic [3:0]  src_code;
  logic [3:0]  dst_code;

  assign src_code = opnd0[7:4];
  assign dst_code = opnd0[3:0];

  function automatic logic [15:0] read_code(input logic [3:0]  code,
                                            input logic [15:0] rx,
                                            input logic [15:0] ry,
                                            input logic [15:0] ru,
                                            input logic [15:0] rs,
                                            input logic [15:0] rpc,
                                            input logic [7:0]  ra,
                                            input logic [7:0]  rb,
                                            input logic [7:0]  rdp,
                                            input logic [7:0]  rcc);
    logic [15:0] v;
    v = 16'hFFFF;
    case (code)
      RC_D:    v = {ra, rb};
      RC_X:    v = rx;
      RC_Y:    v = ry;
      RC_U:    v = ru;
      RC_S:    v = rs;
      RC_PC:   v = rpc;
      RC_DP:   v = {8'hFF, rdp};
      RC_CC:   v = {8'hFF, rcc};
      RC_A:    v = {8'hFF, ra};
      RC_B:    v = {8'hFF, rb};
      default: v = 16'hFFFF;
    endcase
    return v;
  endfunction

  assign rd_src = read_code(src_code, x, y, u, s, pc, a, b, dp, cc);
  assign rd_dst = read_code(dst_code, x, y, u, s, pc, a, b, dp, cc);

  // Transfer context captured at acceptance
  state_t      state_q,     state_d;
  logic        is_exg_q,    is_exg_d;
  logic [3:0]  src_q,       src_d;
  logic [3:0]  dst_q,       dst_d;
  logic [15:0] tmp_src_q,   tmp_src_d;
  logic [15:0] tmp_dst_q,   tmp_dst_d;
  logic        bad_q,       bad_d;

  // Registered outputs
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        wr_q,        wr_d;
  logic [3:0]  wr_sel_q,    wr_sel_d;
  logic [15:0] wr_data_q,   wr_data_d;
  logic        illegal_q,   illegal_d;

  // Next state and next outputs. Outputs are computed for the state being
  // entered, so each one is valid for the whole of its state.
  always_comb begin
    // NOTE: each _d starts as its _q, so a path that leaves one unassigned
    // holds the flop and never infers a latch.
    state_d   = state_q;
    is_exg_d  = is_exg_q;
    src_d     = src_q;
    dst_d     = dst_q;
    tmp_src_d = tmp_src_q;
    tmp_dst_d = tmp_dst_q;
    bad_d     = bad_q;
    busy_d    = busy_q;
    done_d    = done_q;
    wr_d      = wr_q;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    illegal_d = illegal_q;

    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          busy_d    = 1'b0;
          done_d    = 1'b0;
          wr_d      = 1'b0;
          illegal_d = 1'b0;
          if (start && (op == OP_EXG || op == OP_TFR)) begin
            is_exg_d  = (op == OP_EXG);
            src_d     = src_code;
            dst_d     = dst_code;
            tmp_src_d = rd_src;
            tmp_dst_d = rd_dst;
            bad_d     = !code_valid(src_code) || !code_valid(dst_code);
            state_d   = ST_WR1;
            busy_d    = 1'b1;
            // First write: destination takes the source value
            wr_d      = code_valid(dst_code);
            wr_sel_d  = dst_code;
            wr_data_d = write_value(dst_code, rd_src);
          end
        end
        ST_WR1: begin
          if (is_exg_q) begin
            // Second write: source takes the captured destination value
            state_d   = ST_WR2;
            wr_d      = code_valid(src_q);
            wr_sel_d  = src_q;
            wr_data_d = write_value(src_q, tmp_dst_q);
          end else begin
            state_d   = ST_DONE;
            wr_d      = 1'b0;
            done_d    = 1'b1;
            illegal_d = bad_q;
          end
        end
        ST_WR2: begin
          state_d   = ST_DONE;
          wr_d      = 1'b0;
          done_d    = 1'b1;
          illegal_d = bad_q;
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          illegal_d = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          wr_d      = 1'b0;
          illegal_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      is_exg_q  <= 1'b0;
      src_q     <= 4'h0;
      dst_q     <= 4'h0;
      tmp_src_q <= 16'h0000;
      tmp_dst_q <= 16'h0000;
      bad_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_sel_q  <= 4'h0;
      wr_data_q <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_exg_q  <= is_exg_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      tmp_src_q <= tmp_src_d;
      tmp_dst_q <= tmp_dst_d;
      bad_q     <= bad_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_q      <= wr_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr      = wr_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_jtkcpu_regrd.sv
// Testbench for jtkcpu_regrd. Each expected write and completion is queued
// together with the cycle in which it should appear. A negedge monitor pops
// and compares an entry for every write or done the DUT presents with cen high.
module tb_jtkcpu_regrd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [7:0]  opnd0 = 8'h00;
  logic [15:0] x = 16'h1234, y = 16'h5678, u = 16'h9ABC, s_r = 16'hDEF0, pc = 16'h0F1E;
  logic [7:0]  a = 8'h11, b = 8'h22, dp = 8'h33, cc = 8'h44;
  logic        busy, done, wr, illegal;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          is_done;
    logic [3:0]  sel;
    logic [15:0] data;
    bit          ill;
    int          cyc;   // expected cycle, -1 when timing is not checked
  } ev_t;

  ev_t exp_q[$];

  jtkcpu_regrd dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op), .opnd0(opnd0),
    .x(x), .y(y), .u(u), .s(s_r), .pc(pc),
    .a(a), .b(b), .dp(dp), .cc(cc),
    .busy(busy), .done(done), .wr(wr), .wr_sel(wr_sel), .wr_data(wr_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [3:0] sel, input logic [15:0] data, input int c);
    ev_t e;
    e.is_done = 1'b0; e.sel = sel; e.data = data; e.ill = 1'b0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit ill, input int c);
    ev_t e;
    e.is_done = 1'b1; e.sel = 4'h0; e.data = 16'h0; e.ill = ill; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_xfer(input logic [7:0] o, input logic [7:0] p);
    start = 1'b1; op = o; opnd0 = p;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy | done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
    check({tag, "_wr"},      {31'd0, wr},      32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_wr_sel"},  {28'd0, wr_sel},  32'd0);
    check({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
  endtask

  // Scoreboard monitor: one event per cen-qualified write or done
  always @(negedge clk) begin
    if (cen && (wr === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, wr, done}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {31'd0, done}, {31'd0, e.is_done});
        check("event_wr", {31'd0, wr}, {31'd0, !e.is_done});
        if (e.is_done) begin
          check("done_illegal", {31'd0, illegal}, {31'd0, e.ill});
        end else begin
          check("wr_sel", {28'd0, wr_sel}, {28'd0, e.sel});
          check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
        end
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // TFR X->Y
    s0 = cyc; push_wr(4'h2, 16'h1234, s0 + 1); push_done(1'b0, s0 + 2);
    begin_xfer(8'h3F, 8'h12); wait_idle();

    // EXG A<->B
    s0 = cyc; push_wr(4'hB, 16'hFF11, s0 + 1); push_wr(4'hA, 16'hFF22, s0 + 2);
    push_done(1'b0, s0 + 3);
    begin_xfer(8'h3E, 8'hAB); wait_idle();

    // TFR A->X: byte source widened with FF
    a = 8'h5A;
    s0 = cyc; push_wr(4'h1, 16'hFF5A, s0 + 1); push_done(1'b0, s0 + 2);
    begin_xfer(8'h3F, 8'hA1); wait_idle();
    a = 8'h11;

    // TFR X->DP: low byte only
    s0 = cyc; push_wr(4'h8, 16'hFF34, s0 + 1); push_done(1'b0, s0 + 2);
    begin_xfer(8'h3F, 8'h18); wait_idle();

    // Invalid source: x receives FFFF, illegal flagged
    s0 = cyc; push_wr(4'h1, 16'hFFFF, s0 + 1); push_done(1'b1, s0 + 2);
    begin_xfer(8'h3F, 8'h61); wait_idle();

    // Invalid destination: no write, done on time
    s0 = cyc; push_done(1'b1, s0 + 2);
    begin_xfer(8'h3F, 8'h16); wait_idle();

    // EXG X<->Y with the bank changing after acceptance: still a true swap
    s0 = cyc; push_wr(4'h2, 16'h1234, s0 + 1); push_wr(4'h1, 16'h5678, s0 + 2);
    push_done(1'b0, s0 + 3);
    begin_xfer(8'h3E, 8'h12);
    x = 16'hBBBB; y = 16'hAAAA;
    wait_idle();
    x = 16'h1234; y = 16'h5678;

    // EXG U<->U: same value written twice
    s0 = cyc; push_wr(4'h3, 16'h9ABC, s0 + 1); push_wr(4'h3, 16'h9ABC, s0 + 2);
    push_done(1'b0, s0 + 3);
    begin_xfer(8'h3E, 8'h33); wait_idle();

    // EXG D<->A: mixed widths in both directions
    s0 = cyc; push_wr(4'hA, 16'hFF22, s0 + 1); push_wr(4'h0, 16'hFF11, s0 + 2);
    push_done(1'b0, s0 + 3);
    begin_xfer(8'h3E, 8'h0A); wait_idle();

    // EXG PC<->invalid: first step silent, second writes FFFF to pc
    s0 = cyc; push_wr(4'h5, 16'hFFFF, s0 + 2); push_done(1'b1, s0 + 3);
    begin_xfer(8'h3E, 8'h5C); wait_idle();

    // Unsupported opcode is ignored
    begin_xfer(8'h12, 8'h12);
    check("badop_busy0", {31'd0, busy}, 32'd0);
    tick();
    check("badop_busy1", {31'd0, busy}, 32'd0);
    check("badop_done", {31'd0, done}, 32'd0);

    // start held high through a transfer is ignored until IDLE
    s0 = cyc; push_wr(4'hB, 16'hFF11, s0 + 1); push_wr(4'hA, 16'hFF22, s0 + 2);
    push_done(1'b0, s0 + 3);
    start = 1'b1; op = 8'h3E; opnd0 = 8'hAB;
    tick();
    op = 8'h3F; opnd0 = 8'h12;
    repeat (3) tick();
    start = 1'b0;
    wait_idle();

    // cen low for three cycles during WR1: outputs hold, a single write
    push_wr(4'h2, 16'h1234, -1); push_done(1'b0, -1);
    begin_xfer(8'h3F, 8'h12);
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wr", {31'd0, wr}, 32'd1);
      check("stall_sel", {28'd0, wr_sel}, 32'd2);
      check("stall_data", {16'd0, wr_data}, 32'h1234);
    end
    cen = 1'b1;
    wait_idle();

    // Reset during WR1 of an EXG: only the first write happens
    s0 = cyc; push_wr(4'hB, 16'hFF11, s0 + 1);
    begin_xfer(8'h3E, 8'hAB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (4) tick();
    check("midrst_idle", {31'd0, busy}, 32'd0);

    // New request accepted after reset
    s0 = cyc; push_wr(4'h2, 16'h1234, s0 + 1); push_done(1'b0, s0 + 2);
    begin_xfer(8'h3F, 8'h12); wait_idle();

    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
